stream_sel_arbiter: RTL and testbench

- Generates the registered `sel_in` vector for `VX_stream_switch` in its many-to-few configuration (NUM_INPUTS > NUM_OUTPUTS).
- Sits directly upstream of the switch's select port and observes the same `valid_in`/`ready_in` wires as the switch input side.
- Arbitrates round-robin within each output group of NUM_REQS inputs.
- Can hold a grant across a multi-beat packet until its `last` beat is accepted.

---
 rtl/stream_pkg.sv | 46 ++++
 rtl/stream_sel_group.sv | 110 +++++++++++
 rtl/stream_sel_arbiter.sv | 63 ++++++
 tb/tb_stream_sel_arbiter.sv | 240 ++++++++++++++++++++++++
 4 files changed

// File: rtl/stream_pkg.sv
// Shared types and the round-robin pick function for the stream select arbiter.
// Group FSM states and the result of one round-robin search.
package stream_pkg;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_GRANT  = 2'd1,
        ST_LOCKED = 2'd2
    } state_e;

    localparam int MAX_REQS  = 32;
    localparam int MAX_SEL_W = 5;

    typedef struct packed {
        logic                 found;
        logic [MAX_SEL_W-1:0] idx;
    } rr_pick_t;

    // First requester scanning ptr+1, ptr+2, ... modulo n: rotate, priority-encode, un-rotate.
    function automatic rr_pick_t rr_next(input logic [MAX_REQS-1:0] req,
                                         input int ptr,
                                         input int n);
        logic [MAX_REQS-1:0] rot;
        rr_pick_t            res;
        int                  j;
        rot = '0;
        res = '0;
        for (int k = 0; k < MAX_REQS; k++) begin
            if (k < n) begin
                j = ptr + 1 + k;
                if (j >= n) j = j - n;
                rot[k[MAX_SEL_W-1:0]] = req[j[MAX_SEL_W-1:0]];
            end
        end
        for (int k = 0; k < MAX_REQS; k++) begin
            if (!res.found && (k < n) && rot[k[MAX_SEL_W-1:0]]) begin
                j = ptr + 1 + k;
                if (j >= n) j = j - n;
                res.found = 1'b1;
                res.idx   = j[MAX_SEL_W-1:0];
            end
        end
        return res;
    endfunction

endpackage

// File: rtl/stream_sel_group.sv
// One arbitration group: FSM, round-robin pointer and registered select.
module stream_sel_group
    import stream_pkg::*;
#(
    parameter int NUM_REQS  = 4,
    parameter int SEL_W     = 2,
    parameter bit LOCK_MODE = 1'b0
) (
    input  logic                clk,
    input  logic                reset,
    input  logic [NUM_REQS-1:0] i_req,
    input  logic [NUM_REQS-1:0] i_hs,
    input  logic [NUM_REQS-1:0] i_last,
    output logic [SEL_W-1:0]    o_sel,
    output logic                o_grant_valid,
    output logic                o_locked
);

    localparam int PAD = 1 << SEL_W;

    generate
        if (NUM_REQS > MAX_REQS || SEL_W > MAX_SEL_W) begin : g_bad_cfg
            $error("stream_sel_group: NUM_REQS exceeds MAX_REQS");
        end
    endgenerate

    state_e              r_state;
    state_e              w_state_nxt;
    logic [SEL_W-1:0]    r_sel, w_sel_nxt;
    logic [SEL_W-1:0]    r_ptr, w_ptr_nxt;
    logic                r_grant_valid, r_locked;

    // Padded to a power of two so indexing by r_sel never runs off the end.
    logic [PAD-1:0]      w_req, w_hs, w_last;
    logic [MAX_REQS-1:0] w_req_ext, w_req_excl;
    rr_pick_t            w_pick_all, w_pick_excl;
    logic                w_fire, w_sel_last, w_sel_req, w_term;

    assign w_req      = PAD'(i_req);
    assign w_hs       = PAD'(i_hs);
    assign w_last     = PAD'(i_last);
    assign w_req_ext  = MAX_REQS'(i_req);
    assign w_req_excl = w_req_ext & ~(MAX_REQS'(1) << r_sel);

    assign w_pick_all  = rr_next(w_req_ext, int'(r_ptr), NUM_REQS);
    assign w_pick_excl = rr_next(w_req_excl, int'(r_sel), NUM_REQS);

    assign w_fire     = w_hs[r_sel];
    assign w_sel_req  = w_req[r_sel];
    assign w_sel_last = !LOCK_MODE || w_last[r_sel];
    assign w_term     = (r_state != ST_IDLE) && w_fire && w_sel_last;

    always_comb begin
        // NOTE: every output of this block gets a default first, so no path holds a value and no latch is inferred.
        w_state_nxt = r_state;
        w_sel_nxt   = r_sel;
        w_ptr_nxt   = r_ptr;
        if (w_term) begin
            w_ptr_nxt = r_sel;
            if (w_pick_excl.found) begin
                w_sel_nxt   = w_pick_excl.idx[SEL_W-1:0];
                w_state_nxt = ST_GRANT;
            end else begin
                w_state_nxt = ST_IDLE;
            end
        end else begin
            case (r_state)
                ST_IDLE: begin
                    if (w_pick_all.found) begin
                        w_sel_nxt   = w_pick_all.idx[SEL_W-1:0];
                        w_state_nxt = ST_GRANT;
                    end
                end
                ST_GRANT: begin
                    if (w_fire) begin
                        w_state_nxt = ST_LOCKED;
                    end else if (!w_sel_req) begin
                        // Selected input withdrew before any beat moved: re-pick, pointer untouched.
                        if (w_pick_all.found) w_sel_nxt = w_pick_all.idx[SEL_W-1:0];
                        else                  w_state_nxt = ST_IDLE;
                    end
                end
                ST_LOCKED: ;
                default: w_state_nxt = ST_IDLE;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        // NOTE: state registers use non-blocking assignments so every flop samples pre-edge values.
        if (reset) begin
            r_state       <= ST_IDLE;
            r_sel         <= '0;
            r_ptr         <= SEL_W'(NUM_REQS - 1);
            r_grant_valid <= 1'b0;
            r_locked      <= 1'b0;
        end else begin
            r_state       <= w_state_nxt;
            r_sel         <= w_sel_nxt;
            r_ptr         <= w_ptr_nxt;
            r_grant_valid <= (w_state_nxt != ST_IDLE);
            r_locked      <= (w_state_nxt == ST_LOCKED);
        end
    end

    assign o_sel         = r_sel;
    assign o_grant_valid = r_grant_valid;
    assign o_locked      = r_locked;

endmodule

// File: rtl/stream_sel_arbiter.sv
// Registered many-to-few select generator for a stream switch: one round-robin group per output.
module stream_sel_arbiter
    import stream_pkg::*;
#(
    parameter int NUM_INPUTS  = 4,
    parameter int NUM_OUTPUTS = 1,
    parameter int NUM_LANES   = 1,
    parameter bit LOCK_MODE   = 1'b0,
    localparam int NUM_REQS     = (NUM_INPUTS + NUM_OUTPUTS - 1) / NUM_OUTPUTS,
    localparam int LOG_NUM_REQS = $clog2(NUM_REQS),
    localparam int SEL_W        = (LOG_NUM_REQS > 0) ? LOG_NUM_REQS : 1
) (
    input  logic                                  clk,
    input  logic                                  reset,
    input  logic [NUM_INPUTS-1:0][NUM_LANES-1:0]  valid_in,
    input  logic [NUM_INPUTS-1:0][NUM_LANES-1:0]  ready_in,
    input  logic [NUM_INPUTS-1:0]                 last_in,
    output logic [NUM_OUTPUTS-1:0][SEL_W-1:0]     sel_out,
    output logic [NUM_OUTPUTS-1:0]                grant_valid,
    output logic [NUM_OUTPUTS-1:0]                locked
);

    localparam int TOTAL = NUM_OUTPUTS * NUM_REQS;

    logic [TOTAL-1:0] w_req, w_hs, w_last;

    generate
        if (NUM_INPUTS <= NUM_OUTPUTS) begin : g_bad_cfg
            $error("stream_sel_arbiter: NUM_INPUTS must exceed NUM_OUTPUTS");
        end

        // Slots past the last real input are tied off so they never request.
        for (genvar ii = 0; ii < TOTAL; ii++) begin : g_in
            if (ii < NUM_INPUTS) begin : g_real
                assign w_req[ii]  = |valid_in[ii];
                assign w_hs[ii]   = |(valid_in[ii] & ready_in[ii]);
                assign w_last[ii] = last_in[ii];
            end else begin : g_pad
                assign w_req[ii]  = 1'b0;
                assign w_hs[ii]   = 1'b0;
                assign w_last[ii] = 1'b0;
            end
        end

        for (genvar gi = 0; gi < NUM_OUTPUTS; gi++) begin : g_grp
            stream_sel_group #(
                .NUM_REQS  (NUM_REQS),
                .SEL_W     (SEL_W),
                .LOCK_MODE (LOCK_MODE)
            ) u_group (
                .clk           (clk),
                .reset         (reset),
                .i_req         (w_req[gi*NUM_REQS +: NUM_REQS]),
                .i_hs          (w_hs[gi*NUM_REQS +: NUM_REQS]),
                .i_last        (w_last[gi*NUM_REQS +: NUM_REQS]),
                .o_sel         (sel_out[gi]),
                .o_grant_valid (grant_valid[gi]),
                .o_locked      (locked[gi])
            );
        end
    endgenerate

endmodule

// File: tb/tb_stream_sel_arbiter.sv
// Scoreboard bench: three arbiter configurations (4->1 free, 4->1 locking, 6->2 free) on one clock.
module tb_stream_sel_arbiter;

    logic clk = 1'b0;
    logic reset;
    always #5 clk = ~clk;

    logic [3:0][0:0] a_valid, a_ready;
    logic [3:0]      a_last;
    logic [0:0][1:0] a_sel;
    logic [0:0]      a_gv, a_lk;

    logic [3:0][0:0] b_valid, b_ready;
    logic [3:0]      b_last;
    logic [0:0][1:0] b_sel;
    logic [0:0]      b_gv, b_lk;

    logic [5:0][0:0] c_valid, c_ready;
    logic [5:0]      c_last;
    logic [1:0][1:0] c_sel;
    logic [1:0]      c_gv, c_lk;

    stream_sel_arbiter #(.NUM_INPUTS(4), .NUM_OUTPUTS(1), .NUM_LANES(1), .LOCK_MODE(1'b0)) u_a (
        .clk(clk), .reset(reset), .valid_in(a_valid), .ready_in(a_ready), .last_in(a_last),
        .sel_out(a_sel), .grant_valid(a_gv), .locked(a_lk));

    stream_sel_arbiter #(.NUM_INPUTS(4), .NUM_OUTPUTS(1), .NUM_LANES(1), .LOCK_MODE(1'b1)) u_b (
        .clk(clk), .reset(reset), .valid_in(b_valid), .ready_in(b_ready), .last_in(b_last),
        .sel_out(b_sel), .grant_valid(b_gv), .locked(b_lk));

    stream_sel_arbiter #(.NUM_INPUTS(6), .NUM_OUTPUTS(2), .NUM_LANES(1), .LOCK_MODE(1'b0)) u_c (
        .clk(clk), .reset(reset), .valid_in(c_valid), .ready_in(c_ready), .last_in(c_last),
        .sel_out(c_sel), .grant_valid(c_gv), .locked(c_lk));

    localparam int OBS_A_SEL = 0, OBS_A_GV = 1, OBS_A_LK = 2;
    localparam int OBS_B_SEL = 3, OBS_B_GV = 4, OBS_B_LK = 5;
    localparam int OBS_C_SEL0 = 6, OBS_C_GV0 = 7, OBS_C_SEL1 = 8, OBS_C_GV1 = 9, OBS_C_LK0 = 10;

    typedef struct {
        int    code;
        string tag;
        int    want;
    } exp_t;

    exp_t sb[$];
    int   n_tests = 0;
    int   n_fail  = 0;

    function automatic int obs(int code);
        case (code)
            OBS_A_SEL:  return int'(a_sel[0]);
            OBS_A_GV:   return int'(a_gv[0]);
            OBS_A_LK:   return int'(a_lk[0]);
            OBS_B_SEL:  return int'(b_sel[0]);
            OBS_B_GV:   return int'(b_gv[0]);
            OBS_B_LK:   return int'(b_lk[0]);
            OBS_C_SEL0: return int'(c_sel[0]);
            OBS_C_GV0:  return int'(c_gv[0]);
            OBS_C_SEL1: return int'(c_sel[1]);
            OBS_C_GV1:  return int'(c_gv[1]);
            OBS_C_LK0:  return int'(c_lk[0]);
            default:    return -1;
        endcase
    endfunction

    task automatic check(input string tag, input int got, input int want);
        n_tests++;
        if (got !== want) begin
            n_fail++;
            $display("FAIL %s: got %0d, want %0d", tag, got, want);
        end
    endtask

    task automatic expect_out(input int code, input string tag, input int want);
        exp_t e;
        e.code = code;
        e.tag  = tag;
        e.want = want;
        sb.push_back(e);
    endtask

    task automatic exp_a(input string tag, input int sel, input int gv);
        expect_out(OBS_A_SEL, {tag, ".a_sel"}, sel);
        expect_out(OBS_A_GV,  {tag, ".a_gv"},  gv);
        expect_out(OBS_A_LK,  {tag, ".a_lk"},  0);
    endtask

    task automatic exp_b(input string tag, input int sel, input int gv, input int lk);
        expect_out(OBS_B_SEL, {tag, ".b_sel"}, sel);
        expect_out(OBS_B_GV,  {tag, ".b_gv"},  gv);
        expect_out(OBS_B_LK,  {tag, ".b_lk"},  lk);
    endtask

    task automatic exp_c(input string tag, input int sel0, input int gv0, input int sel1, input int gv1);
        expect_out(OBS_C_SEL0, {tag, ".c_sel0"}, sel0);
        expect_out(OBS_C_GV0,  {tag, ".c_gv0"},  gv0);
        expect_out(OBS_C_SEL1, {tag, ".c_sel1"}, sel1);
        expect_out(OBS_C_GV1,  {tag, ".c_gv1"},  gv1);
        expect_out(OBS_C_LK0,  {tag, ".c_lk0"},  0);
    endtask

    // Advance one clock, then retire every expectation queued for this edge.
    task automatic step();
        exp_t e;
        @(posedge clk);
        #1;
        while (sb.size() != 0) begin
            e = sb.pop_front();
            check(e.tag, obs(e.code), e.want);
        end
    endtask

    initial begin
        int seq_a[5];
        int seq_c0[5];
        int seq_c1gv[5];
        seq_a    = '{0, 1, 2, 3, 0};
        seq_c0   = '{0, 2, 0, 2, 0};
        seq_c1gv = '{1, 0, 1, 0, 1};

        reset   = 1'b1;
        a_valid = '0; a_ready = '0; a_last = '0;
        b_valid = '0; b_ready = '0; b_last = '0;
        c_valid = '0; c_ready = '0; c_last = '0;

        exp_a("reset", 0, 0);
        exp_b("reset", 0, 0, 0);
        exp_c("reset", 0, 0, 0, 0);
        step();
        reset = 1'b0;

        // 4->1 free-running round robin, all requesting, always ready.
        a_ready = '1;
        a_valid = 4'b1111;
        for (int i = 0; i < 5; i++) begin
            exp_a($sformatf("rr%0d", i), seq_a[i], 1);
            step();
        end
        a_valid = '0;
        exp_a("rr_idle", 0, 0);
        step();

        // Selected input withdraws without firing: re-pick with the pointer left alone.
        a_ready = '0;
        a_valid = 4'b1000;
        exp_a("drop_sel3", 3, 1);
        step();
        a_valid = 4'b0010;
        exp_a("drop_to1", 1, 1);
        step();
        a_valid = 4'b0110;
        a_ready = '1;
        exp_a("after1_to2", 2, 1);
        step();
        a_valid = '0;
        a_ready = '0;
        exp_a("drop_idle", 2, 0);
        step();
        a_valid = 4'b1000;
        exp_a("sel3_again", 3, 1);
        step();
        a_valid = 4'b0101;
        exp_a("ptr_kept", 2, 1);
        step();
        a_valid = '0;
        exp_a("idle2", 2, 0);
        step();

        // Locking mode: 3-beat packet on input 2 with input 0 waiting.
        b_ready = '1;
        b_valid = 4'b0100;
        exp_b("pkt_grant", 2, 1, 0);
        step();
        b_valid = 4'b0101;
        exp_b("pkt_beat1", 2, 1, 1);
        step();
        exp_b("pkt_beat2", 2, 1, 1);
        step();
        b_last = 4'b0100;
        exp_b("pkt_last", 0, 1, 0);
        step();
        b_valid = 4'b0001;
        b_last  = 4'b0001;
        exp_b("pkt_in0", 0, 0, 0);
        step();
        b_valid = '0;
        b_last  = '0;

        // Lock on input 1, then input 1 goes quiet while others request.
        b_valid = 4'b0010;
        exp_b("hold_grant", 1, 1, 0);
        step();
        exp_b("hold_lock", 1, 1, 1);
        step();
        b_valid = 4'b1001;
        for (int i = 0; i < 5; i++) begin
            exp_b($sformatf("hold_gap%0d", i), 1, 1, 1);
            step();
        end
        b_valid = 4'b1011;
        b_last  = 4'b0010;
        exp_b("hold_release", 3, 1, 0);
        step();
        b_valid = '0;
        b_last  = '0;
        exp_b("hold_idle", 3, 0, 0);
        step();

        // 6->2: group 0 alternates 0/2, group 1 has a lone requester.
        c_ready = '1;
        c_valid = 6'b010101;
        for (int i = 0; i < 5; i++) begin
            exp_c($sformatf("grp%0d", i), seq_c0[i], 1, 1, seq_c1gv[i]);
            step();
        end
        c_valid = '0;
        exp_c("grp_idle", 0, 0, 1, 0);
        step();

        // Reset while locked aborts the packet; the next grant starts from j=0.
        b_ready = '1;
        b_valid = 4'b0100;
        exp_b("rst_grant", 2, 1, 0);
        step();
        exp_b("rst_lock", 2, 1, 1);
        step();
        reset = 1'b1;
        exp_b("rst_abort", 0, 0, 0);
        step();
        reset   = 1'b0;
        b_valid = 4'b0101;
        exp_b("rst_regrant", 0, 1, 0);
        step();
        b_valid = '0;

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
